cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Memory-side counterpart of the cache data array. Converts full cache lines to and from fixed-size bursts on the physical memory bus.
- Read path: the cache controller requests a line fill, the adaptor collects the burst beats into one line, and the line is written into the data array.
- Write path: the adaptor takes a dirty line read out of the data array and serializes it into bursts for writeback.
- Sits between the cache controller/data array and main memory; one transaction is outstanding at a time.

Parameters:
- s_offset, 5, log2 of bytes per line. s_line = 8*2**s_offset = 256 bits.
- s_burst, 64, width in bits of one memory beat. Beats per line: NB = s_line/s_burst = 4. s_line must be an integer multiple of s_burst.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- line_i  in  s_line  line to write back; sampled at request accept.
- line_o  out  s_line  assembled fill line; valid while resp_o=1 and held afterwards.
- address_i  in  32  byte address of the line request.
- read_i  in  1  line fill request (level; sampled in IDLE).
- write_i  in  1  line writeback request (level; sampled in IDLE).
- resp_o  out  1  one-cycle completion pulse to the cache side.
- burst_i  in  s_burst  memory read beat data.
- burst_o  out  s_burst  memory write beat data.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe: one read beat valid, or one write beat accepted, per high cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; beat counter=0; read_o, write_o, resp_o=0; address_o, line_o, burst_o=0. This applies mid-burst too: the transaction is dropped with no resp_o, and the line buffer is cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1 at a clock edge: latch address_i with the low s_offset bits forced to 0 into address_o, latch line_i into the buffer, beat count=0, go to WRITE.
  - Else read_i=1: latch the aligned address, beat count=0, go to READ.
  - write_i and read_i both high: write wins (writeback before fill); read_i is re-sampled after DONE.
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1 for the whole state; first asserted the cycle after the request edge.
  - Each cycle with resp_i=1: burst_i goes into buffer bits [s_burst*k +: s_burst] for beat k, then k increments. Beat 0 is the least-significant.
  - Gaps with resp_i=0 are allowed; the counter holds.
  - On the edge capturing beat NB-1, go to DONE; read_o drops in the same edge.
- WRITE:
  - write_o=1 for the whole state.
  - burst_o = buffer[s_burst*k +: s_burst], combinational from the current k.
  - Each resp_i=1 cycle advances k; burst_o changes on the following cycle.
  - The edge accepting beat NB-1 goes to DONE; write_o drops.
- DONE:
  - resp_o=1 for exactly one cycle; line_o = buffer (fill data for reads, the unmodified written line for writes).
  - Return to IDLE unconditionally. A request seen in DONE is not accepted until IDLE.
- line_o is a register output equal to the buffer at all times. It holds its value after resp_o until the next transaction modifies the buffer.
- address_o holds its value through DONE and keeps the last value in IDLE.
- read_i/write_i changes while busy are ignored; the cache side must hold its request until resp_o.
- resp_i arriving in DONE is ignored. A memory that sends more than NB strobes is a protocol violation, with no required behaviour.
- Request to completion with back-to-back beats: accept edge T; beats at T+1..T+4; resp_o high in cycle T+5.

Test Plan:
- Reset mid-READ after 2 beats: read_o, resp_o go 0 immediately (async); line_o=0; then a fresh read completes normally.
- Read, address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back: address_o=0x0000_1220; read_o high 4 cycles; resp_o one pulse at T+5; line_o = {0x44..,0x33..,0x22..,0x11..}.
- Read with resp_i gaps (pattern 1,0,0,1,1,0,1): four beats are captured in order; resp_o arrives one cycle after the last strobe; no extra beats are captured.
- Write, line_i = 0x0123...EF (256-bit pattern), address 0x8000_001F: address_o=0x8000_0000. burst_o sequence = line_i[63:0], [127:64], [191:128], [255:192], advancing only on resp_i. write_o drops after the 4th strobe; single resp_o.
- read_i and write_i high together in IDLE: write completes first (write_o, resp_o); with read_i still held, the read starts in the cycle after IDLE is re-entered.
- resp_i toggling in IDLE, and read_i pulsed during WRITE: no state change, no resp_o, burst order unaffected.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor, bundled as one bus.
// The slave modport is the adaptor's view; the master modport is the surrounding system's view.
interface cacheline_adaptor_if #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
);
  localparam int s_line = 8 * (2 ** s_offset);

  // cache side
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  // memory side
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole cache lines to and from fixed-width memory bursts.
// One line transaction in flight; writeback takes priority over fill.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
) (
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_if.slave bus
);
  localparam int s_line = 8 * (2 ** s_offset);
  localparam int NB     = s_line / s_burst;
  localparam int KW     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                        state;
  logic [KW-1:0]                 k;
  logic [NB-1:0][s_burst-1:0]    line_buf;
  logic                          last;

  assign last        = (k == KW'(NB - 1));
  assign bus.line_o  = line_buf;
  assign bus.burst_o = line_buf[k];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      k             <= '0;
      line_buf      <= '0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_o <= 1'b0;
          // writeback before fill so a dirty victim is never lost
          if (bus.write_i) begin
            bus.address_o <= bus.address_i & ALIGN_MASK;
            line_buf      <= bus.line_i;
            k             <= '0;
            bus.write_o   <= 1'b1;
            state         <= WRITE;
          end else if (bus.read_i) begin
            bus.address_o <= bus.address_i & ALIGN_MASK;
            k             <= '0;
            bus.read_o    <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_buf[k] <= bus.burst_i;
            if (last) begin
              k          <= '0;
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
              state      <= DONE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            if (last) begin
              k           <= '0;
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
              state       <= DONE;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: stimulus pushes expected completions and
// write beats into queues, negedge monitors pop and compare as the DUT presents them.
module tb_cacheline_adaptor;
  localparam int SO = 5;
  localparam int SB = 64;
  localparam int SL = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.s_offset(SO), .s_burst(SB)) bus();
  cacheline_adaptor #(.s_offset(SO), .s_burst(SB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0]   addr;
    logic [SL-1:0] line;
  } exp_t;

  exp_t          exp_q[$];
  logic [SB-1:0] beat_q[$];

  task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // completion monitor
  always @(negedge clk) begin
    if (rst && bus.resp_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_resp: got resp_o=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_line", bus.line_o, e.line);
        chk("resp_addr", bus.address_o, e.addr);
      end
    end
  end

  // write-beat monitor
  always @(negedge clk) begin
    if (rst && bus.write_o && bus.resp_i) begin
      if (beat_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_beat: got burst_o=%0h expected no beat", bus.burst_o);
      end else begin
        logic [SB-1:0] b;
        b = beat_q.pop_front();
        chk("burst_o", bus.burst_o, b);
      end
    end
  end

  task automatic start_read(input logic [31:0] addr, input logic [31:0] exp_addr);
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    step();
    bus.read_i = 1'b0;
    chk("read_o_start", bus.read_o, 1);
    chk("address_o_rd", bus.address_o, exp_addr);
  endtask

  task automatic feed_read(input logic [SL-1:0] line, input logic [15:0] pat, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      chk("read_o_busy", bus.read_o, 1);
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? line[k*SB +: SB] : {SB{1'b1}};
      if (pat[i]) k++;
      step();
    end
    bus.resp_i = 1'b0;
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [SL-1:0] line, input logic [15:0] pat, input int n);
    exp_t e;
    e.addr = exp_addr;
    e.line = line;
    exp_q.push_back(e);
    start_read(addr, exp_addr);
    feed_read(line, pat, n);
    chk("resp_o_done", bus.resp_o, 1);
    chk("read_o_drop", bus.read_o, 0);
    // stray strobe during DONE must not be captured
    bus.resp_i  = 1'b1;
    bus.burst_i = {SB{1'b1}};
    step();
    bus.resp_i = 1'b0;
    chk("resp_o_pulse", bus.resp_o, 0);
    chk("line_o_hold", bus.line_o, line);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [SL-1:0] line, input logic [15:0] pat, input int n,
                            input bit pulse_read);
    exp_t e;
    int k = 0;
    e.addr = exp_addr;
    e.line = line;
    exp_q.push_back(e);
    for (int j = 0; j < 4; j++) beat_q.push_back(line[j*SB +: SB]);
    bus.line_i    = line;
    bus.address_i = addr;
    bus.write_i   = 1'b1;
    step();
    bus.write_i = 1'b0;
    chk("write_o_start", bus.write_o, 1);
    chk("address_o_wr", bus.address_o, exp_addr);
    for (int i = 0; i < n; i++) begin
      chk("write_o_busy", bus.write_o, 1);
      chk("burst_o_hold", bus.burst_o, line[k*SB +: SB]);
      bus.resp_i = pat[i];
      bus.read_i = pulse_read && (i == 1);
      if (pat[i]) k++;
      step();
    end
    bus.resp_i = 1'b0;
    bus.read_i = 1'b0;
    chk("resp_o_wdone", bus.resp_o, 1);
    chk("write_o_drop", bus.write_o, 0);
    step();
    chk("resp_o_wpulse", bus.resp_o, 0);
    chk("read_o_ignored", bus.read_o, 0);
  endtask

  localparam logic [SL-1:0] L_A = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [SL-1:0] L_G = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
  localparam logic [SL-1:0] L_W = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  localparam logic [SL-1:0] L_R = 256'h5555AAAA5555AAAA_6666777766667777_8888999988889999_0000FFFF0000FFFF;

  initial begin
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    step();
    step();
    chk("rst_read_o", bus.read_o, 0);
    chk("rst_write_o", bus.write_o, 0);
    chk("rst_resp_o", bus.resp_o, 0);
    chk("rst_address_o", bus.address_o, 0);
    chk("rst_line_o", bus.line_o, 0);
    chk("rst_burst_o", bus.burst_o, 0);
    rst = 1'b1;
    step();

    // reset in the middle of a fill drops it and clears the buffer
    start_read(32'h0000_0100, 32'h0000_0100);
    feed_read(L_A, 16'b11, 2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_read_o", bus.read_o, 0);
    chk("midrst_resp_o", bus.resp_o, 0);
    chk("midrst_line_o", bus.line_o, 0);
    step();
    rst = 1'b1;
    step();
    read_line(32'h0000_0100, 32'h0000_0100, L_G, 16'b1111, 4);

    // back-to-back fill
    read_line(32'h0000_1234, 32'h0000_1220, L_A, 16'b1111, 4);

    // fill with strobe gaps 1,0,0,1,1,0,1
    read_line(32'h0000_005F, 32'h0000_0040, L_G, 16'b1011001, 7);

    // writeback with gaps 1,0,1,1,0,0,1
    write_line(32'h8000_001F, 32'h8000_0000, L_W, 16'b1001101, 7, 1'b0);

    // simultaneous requests: write first, read starts once IDLE is re-entered
    begin
      exp_t e;
      e.addr = 32'h0000_3000;
      e.line = L_W;
      exp_q.push_back(e);
      for (int j = 0; j < 4; j++) beat_q.push_back(L_W[j*SB +: SB]);
      e.line = L_R;
      exp_q.push_back(e);
    end
    bus.line_i    = L_W;
    bus.address_i = 32'h0000_3008;
    bus.write_i   = 1'b1;
    bus.read_i    = 1'b1;
    step();
    bus.write_i = 1'b0;
    chk("both_write_o", bus.write_o, 1);
    chk("both_read_o", bus.read_o, 0);
    bus.resp_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.resp_i = 1'b0;
    chk("both_resp_o", bus.resp_o, 1);
    chk("both_read_o_done", bus.read_o, 0);
    step();
    chk("both_read_o_idle", bus.read_o, 0);
    step();
    chk("both_read_o_start", bus.read_o, 1);
    bus.read_i = 1'b0;
    feed_read(L_R, 16'b1111, 4);
    chk("both_resp_o_rd", bus.resp_o, 1);
    step();

    // resp_i noise in IDLE
    for (int i = 0; i < 6; i++) begin
      bus.resp_i = i[0];
      step();
      chk("idle_read_o", bus.read_o, 0);
      chk("idle_write_o", bus.write_o, 0);
      chk("idle_resp_o", bus.resp_o, 0);
    end
    bus.resp_i = 1'b0;

    // read_i pulsed mid-writeback is ignored
    write_line(32'h0000_4444, 32'h0000_4440, L_R, 16'b11011, 5, 1'b1);

    step();
    step();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("beat_q_empty", beat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
